mc_ctrl_fsm: RTL
================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Per state it drives PC, IR, register-file, ALU and memory enables.
//  Memory accesses use a variable-latency req/ready handshake with a watchdog.
//  It handles R-type, lw, sw, beq and jal, and sits between the shared memory port and the datapath muxes.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles mem_req may wait for mem_ready; 0 disables watchdog
//  PERF_W          32   width of perf counters (only with MC_CTRL_PERF_EN)
// PORTS
//  clk          in   1  clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  run          in   1  1 = start/continue fetching; sampled at instruction boundaries
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  mem_ready    in   1  memory completes the access this cycle
//  mem_req      out  1  memory access request
//  mem_we       out  1  write (sw) when mem_req=1
//  iord         out  1  0 = address from PC, 1 = from ALUOut
//  ir_write     out  1  load IR
//  pc_write     out  1  unconditional PC load
//  pc_write_cond out 1  PC load if ALU zero (beq)
//  pc_source    out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
//  alu_src_a    out  1  0 = PC, 1 = rs
//  alu_src_b    out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op       out  2  00 add, 01 sub, 10 funct-decoded
//  reg_dst      out  1  1 = rd, 0 = rt
//  mem_to_reg   out  1  1 = MDR, 0 = ALUOut
//  reg_write    out  1  register-file write
//  jal          out  1  write PC+4 into $31
//  instr_done   out  1  1-cycle pulse in the last cycle of every instruction
//  illegal_op   out  1  1-cycle pulse in DECODE on an unsupported opcode
//  mem_timeout  out  1  sticky; cleared only by reset
//  busy         out  1  state != IDLE
// BEHAVIOUR
//  - Reset: async to IDLE; every output 0 immediately, mem_timeout 0; reset mid-access drops mem_req at once.
//  - IDLE: all outputs 0. Goes to FETCH when run=1.
//  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
//      ir_write and pc_write are asserted only in the cycle with mem_ready=1; the FSM then moves to DECODE.
//      With mem_ready=0 the FSM holds in FETCH with outputs stable.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
//      000000 -> EXEC_R; 100011/101011 -> MEMADR; 000100 -> BRANCH; 000011 -> JAL.
//      Other opcodes: pulse illegal_op and instr_done, then return to boundary (treated as NOP).
//  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB.
//  - ALU_WB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1.
//  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD (lw) or MEM_WR (sw).
//  - MEM_RD: mem_req=1, iord=1; advances to MEM_WB on mem_ready.
//  - MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1.
//  - MEM_WR: mem_req=1, mem_we=1, iord=1; instr_done asserted in the mem_ready cycle.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
//  - JAL: jal=1, reg_write=1, pc_write=1, pc_source=10, instr_done=1.
//  - Boundary = any cycle with instr_done=1. Next state is FETCH if run=1, else IDLE.
//      Deasserting run mid-instruction never aborts the instruction.
//  - Latency with zero-wait memory (FETCH..done, cycles): R=4, lw=5, sw=4, beq=3, jal=3, illegal=2.
//      Each wait cycle adds 1.
//  - Watchdog: an 8-bit-or-wider counter runs while mem_req=1 and mem_ready=0, and clears on handshake.
//      On reaching TIMEOUT_CYCLES: set mem_timeout, drop mem_req, go to IDLE.
//      While mem_timeout=1 the FSM stays in IDLE regardless of run.
//  - mem_ready while mem_req=0 is ignored.
// CONFIGURATION
//  Macro MC_CTRL_PERF_EN.
//  - Defined: adds outputs cycle_cnt[PERF_W] (increments every cycle busy=1) and
//    retired_cnt[PERF_W] (increments on instr_done). Both reset to 0 and wrap modulo 2^PERF_W.
//  - Undefined: ports and logic absent; the rest of the behaviour is identical.
// STRUCTURE
//  - Package mips_ctrl_pkg holds:
//      opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_JAL);
//      the state encoding (IDLE, FETCH, DECODE, EXEC_R, ALU_WB, MEMADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL);
//      ALU_SRC_B_*, PC_SRC_* and ALUOP_* constants.
//  - One sub-module, mc_perf_counters, is instantiated only under MC_CTRL_PERF_EN.
//  - State register plus next-state logic, a combinational output decode, and the watchdog all stay in mc_ctrl_fsm.
// TESTING
//  1. Reset, run=1, ready tied 1, opcode=000000:
//     FETCH->DECODE->EXEC_R->ALU_WB; reg_write=1 only in cycle 4; instr_done at cycle 4; back to FETCH.
//  2. lw, mem_ready low 3 cycles in FETCH and 2 in MEM_RD:
//     instr_done 10 cycles after FETCH entry; ir_write exactly 1 cycle; mem_req steady while waiting.
//  3. sw, then beq, then jal back-to-back:
//     mem_we only in MEM_WR; pc_write_cond only in BRANCH; jal+reg_write+pc_write one cycle; run totals 4+3+3 cycles.
//  4. opcode=111111: illegal_op and instr_done pulse in DECODE; no reg_write/mem_req beyond FETCH; next FETCH follows.
//  5. TIMEOUT_CYCLES=4, mem_ready stuck 0:
//     mem_timeout set after 4 wait cycles; FSM in IDLE; run=1 ignored until rst_n low.
//  6. Drop run during EXEC_R; separately assert rst_n low in MEM_RD:
//     case 1 completes ALU_WB then IDLE; case 2 drops all outputs to 0 asynchronously.
//     With MC_CTRL_PERF_EN, retired_cnt=1 after case 1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, state encoding and control-word layout for the multi-cycle MIPS sequencer.
// Pure declarations; no latency or flow control of its own.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] ALU_SRC_B_RT      = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, ALU_WB, MEMADR,
    MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       jal;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// Busy-cycle and retired-instruction counters, wrapping modulo 2^PERF_W.
// Counts land one cycle after the qualifying cycle; never stalls anything.
module mc_perf_counters #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              busy,
  input  logic              instr_done,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] retired_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (busy)       cycle_cnt   <= cycle_cnt + 1'b1;
      if (instr_done) retired_cnt <= retired_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer; controls decode combinationally from state (and mem_ready on handshakes).
// Memory phases stall until mem_ready, bounded by a watchdog; MC_CTRL_PERF_EN adds perf counters.
module mc_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int PERF_W         = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       jal,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic       busy
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] retired_cnt
`endif
);

  localparam int WD_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

  state_t            state;
  ctrl_t             ctl;
  logic [WD_W-1:0]   wd_cnt;
  logic              wait_cyc;
  logic              wd_fire;

  always_comb begin
    ctl = '0;
    case (state)
      FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = ALU_SRC_B_FOUR;
        ctl.alu_op    = ALUOP_ADD;
        ctl.pc_source = PC_SRC_ALU;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctl.alu_src_b  = ALU_SRC_B_IMM_SH2;
        ctl.alu_op     = ALUOP_ADD;
        ctl.illegal_op = !op_supported(opcode);
        ctl.instr_done = !op_supported(opcode);
      end
      EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALU_SRC_B_RT;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      ALU_WB: begin
        ctl.reg_dst    = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALU_SRC_B_IMM;
        ctl.alu_op    = ALUOP_ADD;
      end
      MEM_RD: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
      end
      MEM_WB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      MEM_WR: begin
        ctl.mem_req    = 1'b1;
        ctl.mem_we     = 1'b1;
        ctl.iord       = 1'b1;
        ctl.instr_done = mem_ready;
      end
      BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = ALU_SRC_B_RT;
        ctl.alu_op        = ALUOP_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PC_SRC_ALUOUT;
        ctl.instr_done    = 1'b1;
      end
      JAL: begin
        ctl.jal        = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = PC_SRC_JUMP;
        ctl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // The watchdog fires on the last permitted wait cycle, so the next cycle is already IDLE.
  assign wait_cyc = ctl.mem_req && !mem_ready;
  assign wd_fire  = WD_EN && wait_cyc && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_timeout <= 1'b0;
      wd_cnt      <= '0;
    end else if (wd_fire) begin
      state       <= IDLE;
      mem_timeout <= 1'b1;
      wd_cnt      <= '0;
    end else begin
      wd_cnt <= wait_cyc ? wd_cnt + 1'b1 : '0;
      case (state)
        IDLE:   if (run && !mem_timeout) state <= FETCH;
        FETCH:  if (mem_ready) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_RTYPE:     state <= EXEC_R;
            OP_LW, OP_SW: state <= MEMADR;
            OP_BEQ:       state <= BRANCH;
            OP_JAL:       state <= JAL;
            default:      state <= run ? FETCH : IDLE;
          endcase
        end
        EXEC_R: state <= ALU_WB;
        MEMADR: state <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD: if (mem_ready) state <= MEM_WB;
        MEM_WR: if (mem_ready) state <= run ? FETCH : IDLE;
        ALU_WB, MEM_WB, BRANCH, JAL: state <= run ? FETCH : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req       = ctl.mem_req;
  assign mem_we        = ctl.mem_we;
  assign iord          = ctl.iord;
  assign ir_write      = ctl.ir_write;
  assign pc_write      = ctl.pc_write;
  assign pc_write_cond = ctl.pc_write_cond;
  assign pc_source     = ctl.pc_source;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign alu_op        = ctl.alu_op;
  assign reg_dst       = ctl.reg_dst;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign reg_write     = ctl.reg_write;
  assign jal           = ctl.jal;
  assign instr_done    = ctl.instr_done;
  assign illegal_op    = ctl.illegal_op;
  assign busy          = (state != IDLE);

`ifdef MC_CTRL_PERF_EN
  mc_perf_counters #(.PERF_W(PERF_W)) u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .busy        (busy),
    .instr_done  (ctl.instr_done),
    .cycle_cnt   (cycle_cnt),
    .retired_cnt (retired_cnt)
  );
`endif

endmodule
